regfile_port_arbiter: RTL

Sequencer and arbiter for the single-ported register file. Shares it between two requesters: the control unit (execute-stage register reads/writes) and the program loader/debug port. Accepts one transaction at a time and grants requesters round-robin. Drives the register file strobes, address and write data from registered outputs, and returns read data with a valid pulse. Sits between the control unit's register interface and the register file.

---
 rtl/regfile_arb_pkg.sv | 23 ++
 rtl/regfile_port_arbiter_rr_pick2.sv | 23 ++
 rtl/regfile_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file port arbiter:
// FSM states, requester indices and the latched transaction.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic REQ_CU = 1'b0;
  localparam logic REQ_LD = 1'b1;

  localparam int unsigned ARB_MAX_W = 32;

  // Widest supported command; ports are zero-extended into it
  typedef struct packed {
    logic                 we;
    logic [ARB_MAX_W-1:0] addr;
    logic [ARB_MAX_W-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the requester
// that did not win last time is chosen.
module rr_pick2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_idx,
  output logic       o_any
);

  always_comb begin
    o_idx = REQ_CU;
    unique case (1'b1)
      (i_req[0] & i_req[1]):  o_idx = ~i_last;
      (i_req[1] & ~i_req[0]): o_idx = REQ_LD;
      default:                o_idx = REQ_CU;
    endcase
  end

  assign o_any = |i_req;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Sequencer sharing the single-ported register file between the
// control unit and the loader/debug port, one transaction at a time.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cu_req,
  input  logic              cu_we,
  input  logic [ADDR_W-1:0] cu_addr,
  input  logic [DATA_W-1:0] cu_wdata,
  output logic              cu_gnt,
  output logic [DATA_W-1:0] cu_rdata,
  output logic              cu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              rf_we,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              addr_err
);

  state_t r_state;
  txn_t   r_cmd;
  txn_t   w_win;
  logic   r_last;
  logic   r_idx;
  logic   r_inrange;

  logic   r_cu_gnt;
  logic   r_ld_gnt;
  logic   r_cu_rvalid;
  logic   r_ld_rvalid;
  logic   r_rf_we;
  logic   r_rf_re;
  logic   r_addr_err;

  logic [DATA_W-1:0] r_cu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic              w_idx;
  logic              w_any;
  logic              w_inrange;
  logic [DATA_W-1:0] w_cap;
  logic              w_unused;

  rr_pick2 u_pick (
    .i_req  ({ld_req, cu_req}),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_win = '0;
    if (w_idx == REQ_LD) begin
      w_win.we    = ld_we;
      w_win.addr  = ARB_MAX_W'(ld_addr);
      w_win.wdata = ARB_MAX_W'(ld_wdata);
    end else begin
      w_win.we    = cu_we;
      w_win.addr  = ARB_MAX_W'(cu_addr);
      w_win.wdata = ARB_MAX_W'(cu_wdata);
    end
  end

  assign w_inrange =
    (w_win.addr < ARB_MAX_W'(NUM_REGS));

  // Out-of-range reads complete with zero data
  assign w_cap = r_inrange ? rf_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_last      <= REQ_LD;
      r_idx       <= REQ_CU;
      r_inrange   <= 1'b0;
      r_cu_gnt    <= 1'b0;
      r_ld_gnt    <= 1'b0;
      r_cu_rvalid <= 1'b0;
      r_ld_rvalid <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_re     <= 1'b0;
      r_addr_err  <= 1'b0;
      r_cu_rdata  <= '0;
      r_ld_rdata  <= '0;
    end else begin
      r_cu_gnt    <= 1'b0;
      r_ld_gnt    <= 1'b0;
      r_cu_rvalid <= 1'b0;
      r_ld_rvalid <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_re     <= 1'b0;
      r_addr_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cmd      <= w_win;
            r_idx      <= w_idx;
            r_last     <= w_idx;
            r_inrange  <= w_inrange;
            r_cu_gnt   <= (w_idx == REQ_CU);
            r_ld_gnt   <= (w_idx == REQ_LD);
            r_rf_we    <= w_inrange & w_win.we;
            r_rf_re    <= w_inrange & ~w_win.we;
            r_addr_err <= ~w_inrange;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_state <= r_cmd.we ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          if (r_idx == REQ_LD) begin
            r_ld_rdata  <= w_cap;
            r_ld_rvalid <= 1'b1;
          end else begin
            r_cu_rdata  <= w_cap;
            r_cu_rvalid <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_unused  = ^{r_cmd.addr, r_cmd.wdata};

  assign cu_gnt    = r_cu_gnt;
  assign ld_gnt    = r_ld_gnt;
  assign cu_rvalid = r_cu_rvalid;
  assign ld_rvalid = r_ld_rvalid;
  assign cu_rdata  = r_cu_rdata;
  assign ld_rdata  = r_ld_rdata;
  assign rf_we     = r_rf_we;
  assign rf_re     = r_rf_re;
  assign rf_addr   = r_cmd.addr[ADDR_W-1:0];
  assign rf_wdata  = r_cmd.wdata[DATA_W-1:0];
  assign addr_err  = r_addr_err;
  assign busy      = (r_state != IDLE);

endmodule
